qdec_cabac_ctrl: RTL and testbench

Slice-level sequencer for the CABAC decoder. It sits between the CABAC register block and the CTU-level CABAC datapath. On a start pulse it latches picture and slice geometry, then drives context-table initialisation. It then issues CTUs one at a time in raster order until end-of-slice, end-of-picture or an error, and reports busy, done and error status back to the register block.

---
 rtl/qdec_cabac_ctrl_pkg.sv | 23 ++
 rtl/qdec_cabac_ctrl_watchdog.sv | 30 +++
 rtl/qdec_cabac_ctrl.sv | 156 +++++++++++++++
 tb/tb_qdec_cabac_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/qdec_cabac_ctrl_pkg.sv
// CABAC slice sequencer shared types.
// State and error encodings used by the controller.
package qdec_cabac_package;

  typedef enum logic [2:0] {
    CABAC_IDLE     = 3'd0,
    CABAC_CFG_CHK  = 3'd1,
    CABAC_CTX_INIT = 3'd2,
    CABAC_ISSUE    = 3'd3,
    CABAC_WAIT     = 3'd4,
    CABAC_DONE     = 3'd5
  } t_cabac_ctrl_state_e;

  typedef enum logic [1:0] {
    CABAC_ERR_NONE    = 2'd0,
    CABAC_ERR_CTU     = 2'd1,
    CABAC_ERR_TIMEOUT = 2'd2,
    CABAC_ERR_CFG     = 2'd3
  } t_cabac_err_e;

  localparam int CABAC_CTX_NUM = 186;

endpackage

// File: rtl/qdec_cabac_ctrl_watchdog.sv
// CTU watchdog: counts enabled cycles since clear.
// expire pulses on the TIMEOUT_CYCLES-th enabled cycle.
module qdec_cabac_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/qdec_cabac_ctrl.sv
// Slice-level CABAC sequencer: config check, context
// init, then raster-order CTU issue with a watchdog.
module qdec_cabac_ctrl
  import qdec_cabac_package::*;
#(
  parameter int CTX_NUM        = CABAC_CTX_NUM,
  parameter int CTX_IDX_W      = 8,
  parameter int CTB_W          = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cabac_start,
  input  logic [CTB_W-1:0]     cfg_pic_w_ctb,
  input  logic [CTB_W-1:0]     cfg_pic_h_ctb,
  input  logic [CTB_W-1:0]     cfg_slice_x,
  input  logic [CTB_W-1:0]     cfg_slice_y,
  output logic                 ctx_init_valid,
  output logic [CTX_IDX_W-1:0] ctx_init_idx,
  input  logic                 ctx_init_ready,
  output logic                 ctu_start,
  output logic [CTB_W-1:0]     ctu_x,
  output logic [CTB_W-1:0]     ctu_y,
  input  logic                 ctu_done,
  input  logic                 ctu_end_of_slice,
  input  logic                 ctu_error,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           err_code,
  output logic [15:0]          ctu_count
);

  localparam logic [CTX_IDX_W-1:0] IDX_LAST =
    CTX_IDX_W'(CTX_NUM - 1);

  t_cabac_ctrl_state_e state;

  logic [CTB_W-1:0] pic_w;
  logic [CTB_W-1:0] pic_h;
  logic [CTB_W-1:0] sl_x;
  logic [CTB_W-1:0] sl_y;
  logic             cfg_bad;
  logic             row_end;
  logic             last_ctb;
  logic             wd_clr;
  logic             wd_en;
  logic             wd_exp;

  assign cfg_bad = (pic_w == '0) || (pic_h == '0) ||
                   (sl_x >= pic_w) || (sl_y >= pic_h);
  assign row_end  = ctu_x == pic_w - CTB_W'(1);
  assign last_ctb = row_end && (ctu_y == pic_h - CTB_W'(1));

  assign busy           = state != CABAC_IDLE;
  assign done           = state == CABAC_DONE;
  assign ctu_start      = state == CABAC_ISSUE;
  assign ctx_init_valid = state == CABAC_CTX_INIT;

  assign wd_clr = state == CABAC_ISSUE;
  assign wd_en  = state == CABAC_WAIT;

  qdec_cabac_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wd_clr),
    .en    (wd_en),
    .expire(wd_exp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= CABAC_IDLE;
      pic_w        <= '0;
      pic_h        <= '0;
      sl_x         <= '0;
      sl_y         <= '0;
      ctx_init_idx <= '0;
      ctu_x        <= '0;
      ctu_y        <= '0;
      err_code     <= '0;
      ctu_count    <= '0;
    end else begin
      unique case (state)
        CABAC_IDLE: begin
          if (cabac_start) begin
            pic_w     <= cfg_pic_w_ctb;
            pic_h     <= cfg_pic_h_ctb;
            sl_x      <= cfg_slice_x;
            sl_y      <= cfg_slice_y;
            err_code  <= CABAC_ERR_NONE;
            ctu_count <= '0;
            state     <= CABAC_CFG_CHK;
          end
        end
        CABAC_CFG_CHK: begin
          if (cfg_bad) begin
            err_code <= CABAC_ERR_CFG;
            state    <= CABAC_DONE;
          end else begin
            ctx_init_idx <= '0;
            state        <= CABAC_CTX_INIT;
          end
        end
        CABAC_CTX_INIT: begin
          if (ctx_init_ready) begin
            if (ctx_init_idx == IDX_LAST) begin
              ctu_x <= sl_x;
              ctu_y <= sl_y;
              state <= CABAC_ISSUE;
            end else begin
              ctx_init_idx <= ctx_init_idx + CTX_IDX_W'(1);
            end
          end
        end
        CABAC_ISSUE: begin
          state <= CABAC_WAIT;
        end
        CABAC_WAIT: begin
          // a CTU completion wins over a same-cycle timeout
          if (ctu_done) begin
            ctu_count <= ctu_count + 16'd1;
            if (ctu_error) begin
              err_code <= CABAC_ERR_CTU;
              state    <= CABAC_DONE;
            end else if (ctu_end_of_slice) begin
              state <= CABAC_DONE;
            end else if (last_ctb) begin
              err_code <= CABAC_ERR_CFG;
              state    <= CABAC_DONE;
            end else begin
              if (row_end) begin
                ctu_x <= '0;
                ctu_y <= ctu_y + CTB_W'(1);
              end else begin
                ctu_x <= ctu_x + CTB_W'(1);
              end
              state <= CABAC_ISSUE;
            end
          end else if (wd_exp) begin
            err_code <= CABAC_ERR_TIMEOUT;
            state    <= CABAC_DONE;
          end
        end
        CABAC_DONE: begin
          state <= CABAC_IDLE;
        end
        default: begin
          state <= CABAC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qdec_cabac_ctrl.sv
// Self-checking bench for qdec_cabac_ctrl: directed and
// random slices against a raster-index reference model.
module tb_qdec_cabac_ctrl;

  localparam int CTX = 186;
  localparam int TMO = 16;

  logic        clk = 0;
  logic        rst_n;
  logic        cabac_start;
  logic [7:0]  cfg_pic_w_ctb;
  logic [7:0]  cfg_pic_h_ctb;
  logic [7:0]  cfg_slice_x;
  logic [7:0]  cfg_slice_y;
  logic        ctx_init_valid;
  logic [7:0]  ctx_init_idx;
  logic        ctx_init_ready;
  logic        ctu_start;
  logic [7:0]  ctu_x;
  logic [7:0]  ctu_y;
  logic        ctu_done;
  logic        ctu_end_of_slice;
  logic        ctu_error;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [15:0] ctu_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qdec_cabac_ctrl #(
    .CTX_NUM(CTX),
    .CTX_IDX_W(8),
    .CTB_W(8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cabac_start     (cabac_start),
    .cfg_pic_w_ctb   (cfg_pic_w_ctb),
    .cfg_pic_h_ctb   (cfg_pic_h_ctb),
    .cfg_slice_x     (cfg_slice_x),
    .cfg_slice_y     (cfg_slice_y),
    .ctx_init_valid  (ctx_init_valid),
    .ctx_init_idx    (ctx_init_idx),
    .ctx_init_ready  (ctx_init_ready),
    .ctu_start       (ctu_start),
    .ctu_x           (ctu_x),
    .ctu_y           (ctu_y),
    .ctu_done        (ctu_done),
    .ctu_end_of_slice(ctu_end_of_slice),
    .ctu_error       (ctu_error),
    .busy            (busy),
    .done            (done),
    .err_code        (err_code),
    .ctu_count       (ctu_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return {busy, done, ctu_start, ctx_init_valid,
            ctx_init_idx, ctu_x, ctu_y, err_code}
           | {16'd0, ctu_count};
  endfunction

  // One slice: the model numbers CTBs by raster index
  // k = y*w + x and stops at error, end-of-slice or the
  // last CTB of the picture.
  task automatic run_slice(input int w, input int h,
                           input int sx, input int sy,
                           input int eos_n, input int err_n,
                           input bit rnd_rdy, input int dly,
                           input bit hold, input int rst_at);
    int  k, avail, n, ecode, cyc, acc, launch, cd;
    int  last_start, last_done, exp_t;
    bit  bad, fin;
    bad = (w == 0) || (h == 0) || (sx >= w) || (sy >= h);
    k = sy * w + sx;
    avail = bad ? 0 : w * h - k;
    if (bad) begin
      n = 0; ecode = 3;
    end else if (hold) begin
      n = 1; ecode = 2;
    end else if (err_n > 0 && err_n <= avail &&
                 (eos_n == 0 || err_n <= eos_n)) begin
      n = err_n; ecode = 1;
    end else if (eos_n > 0 && eos_n <= avail) begin
      n = eos_n; ecode = 0;
    end else begin
      n = avail; ecode = 3;
    end

    @(negedge clk);
    cfg_pic_w_ctb = w[7:0];
    cfg_pic_h_ctb = h[7:0];
    cfg_slice_x   = sx[7:0];
    cfg_slice_y   = sy[7:0];
    cabac_start   = 1;
    @(negedge clk);
    cabac_start = 0;
    cyc = 1; acc = 0; launch = 0; cd = 0;
    last_start = 0; last_done = 0; fin = 0;
    chk("busy_t1", busy, 1);
    while (!fin && cyc < 4000) begin
      if (cyc == 2) begin
        chk("ctx_valid_t2", ctx_init_valid, !bad);
        chk("done_t2", done, bad);
      end
      if (cyc == 3 && hold) begin
        cfg_pic_w_ctb = 0;
        cabac_start = 1;
      end else begin
        cabac_start = 0;
      end
      if (rst_at > 0 && launch == rst_at && cd > 0) begin
        rst_n = 0;
        ctu_done = 0;
        @(negedge clk);
        chk("rst_outputs", all_out(), 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", ctu_count, 0);
        rst_n = 1;
        return;
      end
      ctu_done = 0;
      ctu_end_of_slice = 1'($urandom);
      ctu_error = 1'($urandom);
      if (ctx_init_valid) begin
        chk("ctx_idx", ctx_init_idx, acc);
        ctx_init_ready = rnd_rdy ? 1'($urandom) : 1'b1;
        if (ctx_init_ready) acc++;
        if ($urandom % 8 == 0) ctu_done = 1;
      end else begin
        ctx_init_ready = 1'($urandom);
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          ctu_done = 1;
          ctu_end_of_slice = (launch == eos_n);
          ctu_error = (launch == err_n);
          last_done = cyc;
        end
      end
      if (ctu_start) begin
        chk("launch_in_range", launch < n, 1);
        if (w > 0) begin
          chk("ctu_x", ctu_x, (k + launch) % w);
          chk("ctu_y", ctu_y, (k + launch) / w);
        end
        if (launch == 0 && !rnd_rdy)
          chk("first_start_t", cyc, 2 + CTX);
        if (launch > 0)
          chk("start_after_done", cyc, last_done + 1);
        launch++;
        last_start = cyc;
        if (!hold) cd = dly;
      end
      if (done) begin
        fin = 1;
        exp_t = bad ? 2 : hold ? last_start + TMO + 1
                               : last_done + 1;
        chk("done_t", cyc, exp_t);
        chk("err_code", err_code, ecode);
        chk("ctu_count", ctu_count, hold ? 0 : n);
        chk("launches", launch, n);
        if (!bad) chk("ctx_accepted", acc, CTX);
      end
      @(negedge clk);
      cyc++;
    end
    cabac_start = 0;
    ctu_done = 0;
    chk("slice_finished", fin, 1);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
    chk("err_sticky", err_code, ecode);
  endtask

  initial begin
    rst_n = 0;
    cabac_start = 0;
    cfg_pic_w_ctb = 0;
    cfg_pic_h_ctb = 0;
    cfg_slice_x = 0;
    cfg_slice_y = 0;
    ctx_init_ready = 0;
    ctu_done = 0;
    ctu_end_of_slice = 0;
    ctu_error = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out(), 0);
    chk("reset_count", ctu_count, 0);
    rst_n = 1;

    run_slice(4, 2, 0, 0, 8, 0, 0, 5, 0, 0);
    run_slice(4, 2, 2, 1, 0, 0, 0, 3, 0, 0);
    run_slice(0, 2, 0, 0, 0, 0, 0, 3, 0, 0);
    run_slice(3, 2, 0, 0, 2, 0, 1, 2, 0, 0);
    run_slice(4, 2, 1, 0, 0, 0, 0, 3, 1, 0);
    run_slice(4, 2, 0, 0, 3, 3, 0, 2, 0, 0);
    run_slice(4, 3, 1, 1, 0, 0, 0, 4, 0, 3);
    run_slice(3, 3, 0, 0, 4, 0, 0, 1, 0, 0);

    for (int i = 0; i < 12; i++) begin
      int w, h, sx, sy, eos_n, err_n;
      w = $urandom_range(1, 5);
      h = $urandom_range(1, 4);
      if ($urandom % 8 == 0) w = 0;
      sx = $urandom_range(0, w);
      sy = $urandom_range(0, h - 1);
      eos_n = $urandom_range(0, 12);
      err_n = ($urandom % 3 == 0) ? $urandom_range(1, 8) : 0;
      run_slice(w, h, sx, sy, eos_n, err_n,
                1'($urandom), $urandom_range(1, 8), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
